// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and control-transfer classification used by the decode stage.
package mips_pkg;

  typedef logic [31:0] word_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic [2:0] {
    CTRL_NONE,
    CTRL_BEQ,
    CTRL_BNE,
    CTRL_J,
    CTRL_JAL,
    CTRL_JR
  } ctrl_e;

  function automatic ctrl_e decode_ctrl(input word_t instr);
    ctrl_e c;
    c = CTRL_NONE;
    case (instr[31:26])
      OP_BEQ:   c = CTRL_BEQ;
      OP_BNE:   c = CTRL_BNE;
      OP_J:     c = CTRL_J;
      OP_JAL:   c = CTRL_JAL;
      OP_RTYPE: c = (instr[5:0] == FUNCT_JR) ? CTRL_JR : CTRL_NONE;
      default:  c = CTRL_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/branch_target.sv
// Classifies the decode-stage instruction and computes its control-transfer target.
module branch_target
  import mips_pkg::*;
(
  input  word_t instr_i,
  input  word_t pcplus4_i,
  input  word_t rd1_i,
  output word_t target_o,
  output logic  is_ctrl_o,
  output ctrl_e ctrl_o
);

  always_comb begin
    ctrl_o    = decode_ctrl(instr_i);
    is_ctrl_o = (ctrl_o != CTRL_NONE);
    target_o  = '0;
    case (ctrl_o)
      CTRL_BEQ, CTRL_BNE: target_o = pcplus4_i + {{14{instr_i[15]}}, instr_i[15:0], 2'b00};
      CTRL_J, CTRL_JAL:   target_o = {pcplus4_i[31:28], instr_i[25:0], 2'b00};
      CTRL_JR:            target_o = rd1_i;
      default:            target_o = '0;
    endcase
  end

endmodule

// File: rtl/stage_decode_branch.sv
// Decode stage: IF/ID register, early control-transfer resolution back to fetch,
// and saturating branch/taken counters.
module stage_decode_branch
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  word_t            instr_F,
  input  word_t            pcplus4_F,
  input  logic             stall_D,
  input  logic             flush_D,
  input  word_t            rd1_D,
  input  word_t            rd2_D,
  output word_t            instr_D,
  output word_t            pcplus4_D,
  output logic             valid_D,
  output logic [4:0]       rs_D,
  output logic [4:0]       rt_D,
  output word_t            pcbranch,
  output logic             pcsrc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  word_t            instr_q, instr_d;
  word_t            pcplus4_q, pcplus4_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;

  word_t target;
  logic  is_ctrl;
  ctrl_e ctrl;
  logic  taken;
  logic  resolve;
  logic  cnt_en;

  branch_target u_branch_target (
    .instr_i   (instr_q),
    .pcplus4_i (pcplus4_q),
    .rd1_i     (rd1_D),
    .target_o  (target),
    .is_ctrl_o (is_ctrl),
    .ctrl_o    (ctrl)
  );

  always_comb begin
    taken = 1'b0;
    case (ctrl)
      CTRL_BEQ:                  taken = (rd1_D == rd2_D);
      CTRL_BNE:                  taken = (rd1_D != rd2_D);
      CTRL_J, CTRL_JAL, CTRL_JR: taken = 1'b1;
      default:                   taken = 1'b0;
    endcase
    resolve = valid_q & ~stall_D & taken;
    cnt_en  = valid_q & ~stall_D & ~flush_D;
  end

  always_comb begin
    instr_d   = instr_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    // flush and squash share the bubble path; resolve is already zero under stall
    if (flush_D || resolve) begin
      instr_d   = '0;
      valid_d   = 1'b0;
      pcplus4_d = pcplus4_F;
    end else if (!stall_D) begin
      instr_d   = instr_F;
      valid_d   = 1'b1;
      pcplus4_d = pcplus4_F;
    end

    bcnt_d = bcnt_q;
    tcnt_d = tcnt_q;
    if (cnt_en && is_ctrl && (bcnt_q != '1)) bcnt_d = bcnt_q + CNT_W'(1);
    if (cnt_en && taken && (tcnt_q != '1))   tcnt_d = tcnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q   <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
      bcnt_q    <= '0;
      tcnt_q    <= '0;
    end else begin
      instr_q   <= instr_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
      bcnt_q    <= bcnt_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign instr_D    = instr_q;
  assign pcplus4_D  = pcplus4_q;
  assign valid_D    = valid_q;
  assign rs_D       = instr_q[25:21];
  assign rt_D       = instr_q[20:16];
  assign pcsrc      = resolve;
  assign pcbranch   = resolve ? target : '0;
  assign branch_cnt = bcnt_q;
  assign taken_cnt  = tcnt_q;

endmodule

// File: tb/tb_stage_decode_branch.sv
// Directed and randomized checks of stage_decode_branch against an arithmetic reference model.
module tb_stage_decode_branch;

  localparam int unsigned TB_CNT_W = 4;
  localparam int unsigned CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic                clk;
  logic                reset;
  logic [31:0]         instr_F, pcplus4_F, rd1_D, rd2_D;
  logic                stall_D, flush_D;
  logic [31:0]         instr_D, pcplus4_D, pcbranch;
  logic                valid_D, pcsrc;
  logic [4:0]          rs_D, rt_D;
  logic [TB_CNT_W-1:0] branch_cnt, taken_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // reference model state
  logic [31:0] m_instr, m_pc;
  bit          m_valid;
  int unsigned m_bc, m_tc;

  stage_decode_branch #(.CNT_W(TB_CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_F    (instr_F),
    .pcplus4_F  (pcplus4_F),
    .stall_D    (stall_D),
    .flush_D    (flush_D),
    .rd1_D      (rd1_D),
    .rd2_D      (rd2_D),
    .instr_D    (instr_D),
    .pcplus4_D  (pcplus4_D),
    .valid_D    (valid_D),
    .rs_D       (rs_D),
    .rt_D       (rt_D),
    .pcbranch   (pcbranch),
    .pcsrc      (pcsrc),
    .branch_cnt (branch_cnt),
    .taken_cnt  (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_decode(output bit is_ctrl, output bit taken, output logic [31:0] tgt);
    int unsigned op, fn;
    longint      imm;
    op  = m_instr >> 26;
    fn  = m_instr & 32'h3F;
    imm = longint'(m_instr & 32'hFFFF);
    if (imm >= 32768) imm = imm - 65536;
    is_ctrl = 1'b0;
    taken   = 1'b0;
    tgt     = '0;
    if (op == 4 || op == 5) begin
      is_ctrl = 1'b1;
      taken   = (op == 4) ? (rd1_D == rd2_D) : (rd1_D != rd2_D);
      tgt     = 32'(longint'(m_pc) + imm * 4);
    end else if (op == 2 || op == 3) begin
      is_ctrl = 1'b1;
      taken   = 1'b1;
      tgt     = (m_pc & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) << 2);
    end else if (op == 0 && fn == 8) begin
      is_ctrl = 1'b1;
      taken   = 1'b1;
      tgt     = rd1_D;
    end
  endfunction

  task automatic check_model();
    bit          ic, tk, ps;
    logic [31:0] tg;
    model_decode(ic, tk, tg);
    ps = m_valid && !stall_D && tk;
    check("instr_D",    instr_D, m_instr);
    check("pcplus4_D",  pcplus4_D, m_pc);
    check("valid_D",    32'(valid_D), 32'(m_valid));
    check("rs_D",       32'(rs_D), (m_instr >> 21) & 32'h1F);
    check("rt_D",       32'(rt_D), (m_instr >> 16) & 32'h1F);
    check("pcsrc",      32'(pcsrc), 32'(ps));
    check("pcbranch",   pcbranch, ps ? tg : 32'h0);
    check("branch_cnt", 32'(branch_cnt), m_bc);
    check("taken_cnt",  32'(taken_cnt), m_tc);
  endtask

  // drive one cycle's inputs just after the edge, then compare mid-cycle
  task automatic apply(input logic [31:0] ins, input logic [31:0] pc4, input logic st,
                       input logic fl, input logic [31:0] r1, input logic [31:0] r2);
    instr_F   = ins;
    pcplus4_F = pc4;
    stall_D   = st;
    flush_D   = fl;
    rd1_D     = r1;
    rd2_D     = r2;
    #3;
    check_model();
  endtask

  task automatic tick();
    bit          ic, tk, ps;
    logic [31:0] tg;
    model_decode(ic, tk, tg);
    ps = m_valid && !stall_D && tk;
    if (m_valid && !stall_D && !flush_D && ic) begin
      if (m_bc < CNT_MAX) m_bc++;
      if (tk && m_tc < CNT_MAX) m_tc++;
    end
    if (flush_D || ps) begin
      m_instr = '0;
      m_valid = 1'b0;
      m_pc    = pcplus4_F;
    end else if (!stall_D) begin
      m_instr = instr_F;
      m_valid = 1'b1;
      m_pc    = pcplus4_F;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_instr"}, instr_D, 32'h0);
    check({tag, "_pc4"},   pcplus4_D, 32'h0);
    check({tag, "_valid"}, 32'(valid_D), 32'h0);
    check({tag, "_pcsrc"}, 32'(pcsrc), 32'h0);
    check({tag, "_pcbr"},  pcbranch, 32'h0);
    check({tag, "_bcnt"},  32'(branch_cnt), 32'h0);
    check({tag, "_tcnt"},  32'(taken_cnt), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    check_all_zero("rst");
    m_instr = '0;
    m_pc    = '0;
    m_valid = 1'b0;
    m_bc    = 0;
    m_tc    = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 6))
      0: w[31:26] = 6'h04;
      1: w[31:26] = 6'h05;
      2: w[31:26] = 6'h02;
      3: w[31:26] = 6'h03;
      4: begin w[31:26] = 6'h00; w[20:6] = '0; w[5:0] = 6'h08; end
      5: w[31:26] = 6'h00;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    reset     = 1'b0;
    instr_F   = 32'h2002_0005;
    pcplus4_F = 32'h0000_0004;
    stall_D   = 1'b0;
    flush_D   = 1'b0;
    rd1_D     = '0;
    rd2_D     = '0;

    // reset, then first instruction lands one edge after release
    do_reset();
    check("rst_pcsrc", 32'(pcsrc), 32'h0);
    apply(32'h2002_0005, 32'h4, 0, 0, 0, 0); tick();
    apply(32'h0000_0020, 32'h8, 0, 0, 0, 0);
    check("first_instr", instr_D, 32'h2002_0005);
    tick();

    // taken beq
    do_reset();
    apply(32'h1043_0003, 32'h100, 0, 0, 0, 0); tick();
    apply(32'h0000_0020, 32'h104, 0, 0, 7, 7);
    check("beq_pcsrc", 32'(pcsrc), 32'h1);
    check("beq_tgt", pcbranch, 32'h10C);
    tick();
    apply(32'h0000_0020, 32'h10C, 0, 0, 0, 0);
    check("beq_squash", 32'(valid_D), 32'h0);
    check("beq_tcnt", 32'(taken_cnt), 32'h1);
    tick();

    // not-taken beq
    do_reset();
    apply(32'h1043_0003, 32'h100, 0, 0, 0, 0); tick();
    apply(32'h0000_0020, 32'h104, 0, 0, 7, 8);
    check("beqnt_pcsrc", 32'(pcsrc), 32'h0);
    tick();
    apply(32'h0000_0020, 32'h108, 0, 0, 0, 0);
    check("beqnt_bcnt", 32'(branch_cnt), 32'h1);
    check("beqnt_tcnt", 32'(taken_cnt), 32'h0);
    tick();

    // j and jr targets
    do_reset();
    apply(32'h0800_0040, 32'h1000_0008, 0, 0, 0, 0); tick();
    apply(32'h0000_0020, 32'h1000_000C, 0, 0, 0, 0);
    check("j_tgt", pcbranch, 32'h1000_0100);
    tick();
    apply(32'h03E0_0008, 32'h2000, 0, 0, 0, 0); tick();
    apply(32'h0000_0020, 32'h2004, 0, 0, 32'h400, 0);
    check("jr_tgt", pcbranch, 32'h400);
    tick();

    // taken bne held by a two-cycle stall
    do_reset();
    apply(32'h1443_0003, 32'h300, 0, 0, 0, 0); tick();
    apply(32'h0000_0020, 32'h304, 1, 0, 1, 2);
    check("stall_pcsrc0", 32'(pcsrc), 32'h0);
    tick();
    apply(32'h0000_0020, 32'h304, 1, 0, 1, 2);
    check("stall_hold", instr_D, 32'h1443_0003);
    check("stall_bcnt", 32'(branch_cnt), 32'h0);
    tick();
    apply(32'h0000_0020, 32'h304, 0, 0, 1, 2);
    check("unstall_pcsrc", 32'(pcsrc), 32'h1);
    check("unstall_tgt", pcbranch, 32'h30C);
    tick();
    apply(32'h0000_0020, 32'h30C, 0, 0, 1, 2);
    check("after_pcsrc", 32'(pcsrc), 32'h0);
    check("after_tcnt", 32'(taken_cnt), 32'h1);
    tick();

    // saturation, then async reset in the middle of a stall
    do_reset();
    for (int i = 0; i < 17; i++) begin
      apply(32'h1043_0003, 32'h100, 0, 0, 5, 5); tick();
      apply(32'h0000_0020, 32'h104, 0, 0, 5, 5); tick();
    end
    apply(32'h1043_0003, 32'h500, 0, 0, 0, 0);
    check("sat_bcnt", 32'(branch_cnt), 32'hF);
    check("sat_tcnt", 32'(taken_cnt), 32'hF);
    tick();
    apply(32'h0000_0020, 32'h504, 1, 0, 3, 3); tick();
    apply(32'h0000_0020, 32'h504, 1, 0, 3, 3);
    #1 reset = 1'b0;
    #1 check_all_zero("async");
    m_instr = '0; m_pc = '0; m_valid = 1'b0; m_bc = 0; m_tc = 0;
    @(posedge clk);
    #1 reset = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] r1;
      if (i % 150 == 0) do_reset();
      r1 = $urandom;
      apply(rand_instr(), $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
            r1, ($urandom_range(0, 1) == 0) ? r1 : $urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
